// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } hz_state_t;

  localparam int              REG_W    = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the ID/EX load and the IF/ID sources.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             id_ex_memread_i,
  input  logic [REG_W-1:0] id_ex_rt_i,
  output logic             lu_hazard_o
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_hazard_o = id_ex_memread_i && (id_ex_rt_i != REG_ZERO) &&
                       ((id_ex_rt_i == if_id_rs_i) ||
                        (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush/freeze sequencer for the five-stage pipe.
// Optional HAZARD_CTRL_PERF_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic             ID_EX_memread,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic             EX_MEM_PCSrc,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_flush,
  output logic             freeze,
  output logic             mem_err
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam int                WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

  hz_state_t         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lu_hazard;
  logic              run_eval;

  load_use_detect u_lu (
    .if_id_rs_i      (IF_ID_rs),
    .if_id_rt_i      (IF_ID_rt),
    .if_id_uses_rt_i (IF_ID_uses_rt),
    .id_ex_memread_i (ID_EX_memread),
    .id_ex_rt_i      (ID_EX_rt),
    .lu_hazard_o     (lu_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_MEM_flush = 1'b0;
    freeze       = 1'b0;
    mem_err      = 1'b0;
    run_eval     = 1'b0;

    case (state_q)
      INIT: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        EX_MEM_flush = 1'b1;
        wait_cnt_d   = '0;
        state_d      = RUN;
      end
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          freeze     = 1'b1;
          wait_cnt_d = WCNT_W'(1);
          state_d    = WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      WAIT: begin
        // The ack cycle unfreezes and is handled like a normal RUN cycle.
        if (dmem_ack) begin
          run_eval   = 1'b1;
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WCNT_MAX) begin
            state_d = ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end
      end
      ERR: begin
        freeze  = 1'b1;
        mem_err = 1'b1;
      end
      default: state_d = INIT;
    endcase

    if (run_eval) begin
      if (EX_MEM_PCSrc) begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        EX_MEM_flush = 1'b1;
      end else if (lu_hazard) begin
        ID_EX_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic        lu_stall;
  logic        br_flush;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  assign lu_stall = run_eval && !EX_MEM_PCSrc && lu_hazard;
  assign br_flush = run_eval && EX_MEM_PCSrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze || lu_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_flush)           flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences, random vs. reference model.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 16;

  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_flush, freeze, mem_err}
  localparam logic [6:0] O_INIT   = 7'b0011100;
  localparam logic [6:0] O_NORMAL = 7'b1100000;
  localparam logic [6:0] O_BRANCH = 7'b1111100;
  localparam logic [6:0] O_LU     = 7'b0001000;
  localparam logic [6:0] O_FREEZE = 7'b0000010;
  localparam logic [6:0] O_ERR    = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic       IF_ID_uses_rt, ID_EX_memread, EX_MEM_PCSrc, dmem_req, dmem_ack;
  logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_flush, freeze, mem_err;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .IF_ID_uses_rt (IF_ID_uses_rt),
    .ID_EX_memread (ID_EX_memread),
    .ID_EX_rt      (ID_EX_rt),
    .EX_MEM_PCSrc  (EX_MEM_PCSrc),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .pc_write      (pc_write),
    .IF_ID_write   (IF_ID_write),
    .IF_ID_flush   (IF_ID_flush),
    .ID_EX_bubble  (ID_EX_bubble),
    .EX_MEM_flush  (EX_MEM_flush),
    .freeze        (freeze),
    .mem_err       (mem_err)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] idex_rt;
    logic       pcsrc, req, ack;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [6:0] exp);
    logic [6:0] act;
    act = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_flush, freeze, mem_err};
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] idrt, input logic pcsrc,
                       input logic req, input logic ack);
    IF_ID_rs = rs; IF_ID_rt = rt; IF_ID_uses_rt = uses; ID_EX_memread = mr;
    ID_EX_rt = idrt; EX_MEM_PCSrc = pcsrc; dmem_req = req; dmem_ack = ack;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit lu_rule(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                 input logic mr, input logic [4:0] idrt);
    return mr && (idrt != 0) && ((idrt == rs) || (uses && (idrt == rt)));
  endfunction

  initial begin
    bit         m_init, m_err, mem_stall;
    int         m_n;
    logic [6:0] exp;
    int unsigned e_stall, e_flush;

    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[1] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[3] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[4] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[5] = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[6] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[7] = '{5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, O_LU};
    vecs[8] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[9] = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, O_NORMAL};

    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", O_INIT);
    end
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("init_cycle", O_INIT);
    cyc();
    @(negedge clk); chk("run_after_init", O_NORMAL);

    for (int i = 0; i < 10; i++) begin
      cyc();
      apply(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].memread,
            vecs[i].idex_rt, vecs[i].pcsrc, vecs[i].req, vecs[i].ack);
      @(negedge clk); chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Load-use lasts one cycle once the load advances
    cyc(); apply(5, 0, 0, 1, 5, 0, 0, 0);
    @(negedge clk); chk("lu_stall", O_LU);
    cyc(); apply(5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lu_release", O_NORMAL);

    // Memory wait with a pending branch
    for (int i = 0; i < 4; i++) begin
      cyc(); apply(0, 0, 0, 0, 0, 1, 1, 0);
      @(negedge clk); chk($sformatf("wait_freeze%0d", i), O_FREEZE);
    end
    cyc(); apply(0, 0, 0, 0, 0, 1, 1, 1);
    @(negedge clk); chk("wait_ack_branch", O_BRANCH);
    cyc(); apply(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("wait_after", O_NORMAL);

    // Timeout from a fresh reset so the counters start at zero
    cyc(); rst_n = 1'b0;
    @(negedge clk); chk("reset_mid_run", O_INIT);
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("init_cycle2", O_INIT);
    for (int k = 1; k <= MAX_WAIT + 1; k++) begin
      cyc(); apply(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk); chk($sformatf("to_freeze%0d", k), O_FREEZE);
`ifdef HAZARD_CTRL_PERF_EN
      chk32($sformatf("to_stall_cnt%0d", k), stall_cnt, 32'(k - 1));
`endif
    end
    cyc();
    @(negedge clk); chk("to_err", O_ERR);
    for (int i = 0; i < 3; i++) begin
      cyc(); apply(0, 0, 0, 0, 0, 1, 0, 1);
      @(negedge clk); chk("err_sticky", O_ERR);
    end
`ifdef HAZARD_CTRL_PERF_EN
    chk32("to_stall_total", stall_cnt, 32'(MAX_WAIT + 4));
    chk32("to_flush_total", flush_cnt, 32'd0);
`endif
    cyc(); rst_n = 1'b0;
    @(negedge clk); chk("err_reset", O_INIT);
`ifdef HAZARD_CTRL_PERF_EN
    chk32("reset_stall_cnt", stall_cnt, 32'd0);
`endif

    // Random stimulus against a rule-level reference model
    m_init = 1'b1; m_err = 1'b0; m_n = 0; e_stall = 0; e_flush = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst_n = (c == 0 || $urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      @(negedge clk);
      mem_stall = 1'b0;
      if (!rst_n || m_init) exp = O_INIT;
      else if (m_err) exp = O_ERR;
      else begin
        mem_stall = (m_n == 0) ? (dmem_req && !dmem_ack) : !dmem_ack;
        if (mem_stall) exp = O_FREEZE;
        else if (EX_MEM_PCSrc) exp = O_BRANCH;
        else if (lu_rule(IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_memread, ID_EX_rt)) exp = O_LU;
        else exp = O_NORMAL;
      end
      chk($sformatf("rand%0d", c), exp);
      if (!rst_n) begin
        m_init = 1'b1; m_err = 1'b0; m_n = 0; e_stall = 0; e_flush = 0;
      end else begin
        if (exp == O_FREEZE || exp == O_ERR || exp == O_LU) e_stall++;
        if (exp == O_BRANCH) e_flush++;
        if (m_init) m_init = 1'b0;
        else if (!m_err) begin
          if (mem_stall) begin
            m_n++;
            if (m_n == MAX_WAIT + 1) m_err = 1'b1;
          end else m_n = 0;
        end
      end
    end
    cyc();
    @(negedge clk);
`ifdef HAZARD_CTRL_PERF_EN
    chk32("rand_stall_cnt", stall_cnt, e_stall);
    chk32("rand_flush_cnt", flush_cnt, e_flush);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage fetch/decode/execute/memory/writeback datapath. It owns every stall, bubble, flush and freeze decision. It detects load-use hazards between the ID/EX and IF/ID registers, squashes wrong-path instructions when a branch resolves taken in EX/MEM, and freezes the whole pipe while data memory is busy. Its outputs drive the PC write enable and the pipeline-register write/flush controls in i_fetch, i_decode and the downstream stage registers.

## Interface
- MAX_WAIT, 16: cycles `freeze` may stay high before the memory timeout fires. Legal range 2..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_rs  in  5  rs field of the instruction in IF/ID
- IF_ID_rt  in  5  rt field of the instruction in IF/ID
- IF_ID_uses_rt  in  1  the IF/ID instruction reads rt as a source
- ID_EX_memread  in  1  the ID/EX instruction is a load
- ID_EX_rt  in  5  load destination register
- EX_MEM_PCSrc  in  1  branch resolved taken
- dmem_req  in  1  MEM stage has a load or store in flight
- dmem_ack  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register load enable
- IF_ID_write  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID loads a NOP on the next edge
- ID_EX_bubble  out  1  ID/EX loads zero control (bubble) on the next edge
- EX_MEM_flush  out  1  EX/MEM loads zero control on the next edge
- freeze  out  1  all pipeline registers and the PC hold
- mem_err  out  1  sticky memory timeout flag

## Operation
- Outputs are Mealy: a combinational function of the registered state and the current inputs.
- States:
  - INIT: reset state; lasts exactly one cycle after `rst_n` deasserts. Asserts all three flushes, `pc_write=0`, `IF_ID_write=0`. Always goes to RUN.
  - RUN: normal operation; all priority rules below apply.
  - WAIT: data memory is busy; the pipe is frozen.
  - ERR: memory timeout; terminal until reset.
- RUN priority, highest first:
  1. **Memory stall.** Condition: `dmem_req && !dmem_ack`. Response: `freeze=1`, `pc_write=0`, `IF_ID_write=0`, no flushes. Go to WAIT and load `wait_cnt=1`.
  2. **Branch taken.** Condition: `EX_MEM_PCSrc=1`. Response: `pc_write=1`, `IF_ID_flush=1`, `ID_EX_bubble=1`, `EX_MEM_flush=1` for exactly one cycle. Load-use detection is ignored in that cycle.
  3. **Load-use.** Condition: `ID_EX_memread && ID_EX_rt!=0 && (ID_EX_rt==IF_ID_rs || (IF_ID_uses_rt && ID_EX_rt==IF_ID_rt))`. Response: `pc_write=0`, `IF_ID_write=0`, `ID_EX_bubble=1`.
  4. **Otherwise.** `pc_write=1`, `IF_ID_write=1`, all flushes 0, `freeze=0`.
- WAIT:
  - `freeze=1`; all enables and flushes 0.
  - On `dmem_ack=1`: `freeze=0` that cycle, RUN priority rules 2-4 are evaluated normally in the same cycle, and the state returns to RUN.
  - Otherwise `wait_cnt` increments. When `wait_cnt==MAX_WAIT` with no ack, go to ERR.
- ERR: `freeze=1`, `mem_err=1`. Held until `rst_n`.
- A branch raised while frozen is not lost. EX/MEM holds its contents, so `EX_MEM_PCSrc` is still high on the ack cycle and takes effect then.
- `wait_cnt` is $clog2(MAX_WAIT+1) bits wide and saturates at MAX_WAIT.

## Timing
- While `rst_n` is low, outputs equal the INIT values: `pc_write=0`, `IF_ID_write=0`, `IF_ID_flush=1`, `ID_EX_bubble=1`, `EX_MEM_flush=1`, `freeze=0`, `mem_err=0`. `wait_cnt` is 0.
- Zero-cycle latency: every decision is visible in the same cycle as its inputs.
- A load-use stall lasts exactly one cycle. On the next edge the load moves to EX/MEM and the compare no longer matches.
- Reset asserted mid-WAIT or in ERR goes immediately to INIT, with the INIT output values.
- An ack arriving in the same cycle as a new request counts as no stall.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined:
  - Adds outputs `stall_cnt[31:0]`, counting cycles with `freeze=1` or a load-use stall.
  - Adds `flush_cnt[31:0]`, counting branch-flush cycles.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor either counter exists, and all other behaviour is identical.

## Structure
- Package `hazard_pkg`:
  - State enum `hz_state_t` (INIT, RUN, WAIT, ERR).
  - `REG_ZERO = 5'd0`.
  - `REG_W = 5`.
- Sub-module `load_use_detect`: purely combinational compare producing `lu_hazard`. It is instantiated once; the parent applies the priority rules.

## Test plan
- **Reset release.** Hold `rst_n=0` for 3 cycles, then release. Expect INIT values during reset and for the first post-reset cycle, then `pc_write=1`, `IF_ID_write=1`.
- **Load-use hazard.** `ID_EX_memread=1`, `ID_EX_rt=5`, `IF_ID_rs=5`. Expect exactly one cycle of `pc_write=0`, `IF_ID_write=0`, `ID_EX_bubble=1`.
- **Register zero never stalls.** Repeat the load-use case with `ID_EX_rt=0`. Expect no stall.
- **Branch beats load-use.** Drive `EX_MEM_PCSrc=1` together with the load-use condition. Expect all three flushes with `pc_write=1`, and no stall.
- **Memory wait with pending branch.** `dmem_req=1`, `dmem_ack=0` for 4 cycles with `EX_MEM_PCSrc=1` held. Expect `freeze=1` for 4 cycles, then on the ack cycle `freeze=0` and the branch flushes fire.
- **Timeout.** With `MAX_WAIT=16`, hold `dmem_req=1`, `dmem_ack=0`. Expect `mem_err=1` after the 16th wait cycle, sticky until reset. With `HAZARD_CTRL_PERF_EN` defined, also check that `stall_cnt` increments on every frozen cycle.
